multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle FSM controller (ports: clk, reset (async low), opcode/funct3/funct7b5, ALU flags in; write strobes, mux selects, imm_src, alu_ctrl, illegal, state out)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111;
  state_t state_q, state_d;
  logic pc_w, ir_w, mem_w, reg_w, ill, taken, zero, sign, carry, ovf;
  logic [3:0] alu_op;
  assign {zero, sign, carry, ovf} = flags;
  assign state = state_q;
  // SUB only for register ops; the shift-right arithmetic bit applies to both forms
  always_comb begin
    alu_op = 4'b0000;
    case (funct3)
      3'b000: alu_op = (state_q == EXECR && funct7b5) ? 4'b0001 : 4'b0000;
      3'b001: alu_op = 4'b1000;
      3'b010: alu_op = 4'b0101;
      3'b011: alu_op = 4'b1001;
      3'b100: alu_op = 4'b0100;
      3'b101: alu_op = funct7b5 ? 4'b0111 : 4'b0110;
      3'b110: alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  end
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = !zero;
      3'b100: taken = sign ^ ovf;
      3'b101: taken = !(sign ^ ovf);
      3'b110: taken = carry;
      3'b111: taken = !carry;
      default: taken = 1'b0;
    endcase
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: case (opcode)
        OP_LOAD, OP_STORE: state_d = MEMADR;
        OP_R:   state_d = EXECR;
        OP_I:   state_d = EXECI;
        OP_BR:  state_d = BRANCH;
        OP_JAL: state_d = JAL;
        OP_LUI: state_d = LUI;
        default: state_d = FETCH;
      endcase
      MEMADR: state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECR, EXECI, JAL, LUI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    ill = 1'b0;
    adr_src = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    result_src = 2'b00;
    imm_src = 3'b000;
    alu_ctrl = 4'b0000;
    case (state_q)
      FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = opcode == OP_STORE ? 3'b001 : opcode == OP_BR ? 3'b010 :
                  opcode == OP_JAL ? 3'b011 : opcode == OP_LUI ? 3'b100 : 3'b000;
        ill = !(opcode inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI});
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl = alu_op;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl = alu_op;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl = 4'b0001;
        pc_w = taken;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w = 1'b1;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src = 3'b100;
      end
      default: ;
    endcase
  end
  // strobes are masked by reset so nothing writes while reset is held, clock or not
  assign pc_write  = pc_w & reset;
  assign ir_write  = ir_w & reset;
  assign mem_write = mem_w & reset;
  assign reg_write = reg_w & reset;
  assign illegal   = ill & reset;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0, funct7b5 = 1'b0;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic [3:0] flags = 4'b0000;
  logic pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, state;
  int checks = 0, errors = 0;
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .flags(flags), .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
  endtask
  function automatic logic [4:0] strobes;
    return {pc_write, ir_write, mem_write, reg_write, illegal};
  endfunction
  initial begin
    #12;
    check("rst_state", state, 0);
    check("rst_strobes", strobes(), 0);
    reset = 1'b1;
    #1;
    check("fetch_state", state, 0);
    check("fetch_strobes", strobes(), 5'b11000);
    check("fetch_b_res", {alu_src_a, alu_src_b, result_src}, 6'b001010);
    // lw
    step; check("lw_s1", state, 1); check("lw_dec_a", alu_src_a, 2'b01); check("lw_imm", imm_src, 0);
    step; check("lw_s2", state, 2); check("lw_madr", {alu_src_a, alu_src_b}, 4'b1001);
    step; check("lw_s3", state, 3); check("lw_rd", {adr_src, reg_write}, 2'b10);
    step; check("lw_s4", state, 4); check("lw_wb", {reg_write, result_src}, 3'b101);
    step; check("lw_s0", state, 0);
    // sw
    instr(7'b0100011, 3'b010, 1'b0);
    step; check("sw_s1", state, 1); check("sw_imm", imm_src, 3'b001);
    step; check("sw_s2", state, 2);
    step; check("sw_s5", state, 5); check("sw_mw", {mem_write, adr_src, reg_write}, 3'b110);
    step; check("sw_s0", state, 0);
    // sub
    instr(7'b0110011, 3'b000, 1'b1);
    step; check("sub_s1", state, 1);
    step; check("sub_s6", state, 6); check("sub_alu", alu_ctrl, 4'b0001); check("sub_b", alu_src_b, 0);
    step; check("sub_s8", state, 8); check("sub_wb", {reg_write, result_src}, 3'b100);
    step; check("sub_s0", state, 0);
    // srai
    instr(7'b0010011, 3'b101, 1'b1);
    step; step; check("srai_s7", state, 7); check("srai_alu", alu_ctrl, 4'b0111);
    step; step; check("srai_s0", state, 0);
    // addi with funct7b5 set stays ADD
    instr(7'b0010011, 3'b000, 1'b1);
    step; step; check("addi_alu", alu_ctrl, 4'b0000);
    step; step;
    // bltu taken on carry, then not taken when flags clear in same cycle
    instr(7'b1100011, 3'b110, 1'b0);
    flags = 4'b0010;
    step; check("bltu_s1", state, 1); check("bltu_imm", imm_src, 3'b010);
    step; check("bltu_s9", state, 9); check("bltu_pc", pc_write, 1); check("br_alu", alu_ctrl, 4'b0001);
    flags = 4'b0000; #1; check("bltu_nt", pc_write, 0);
    step; check("bltu_s0", state, 0);
    // bge: sign==overflow -> taken
    instr(7'b1100011, 3'b101, 1'b0);
    flags = 4'b0101;
    step; step; check("bge_pc", pc_write, 1);
    step;
    // beq with zero clear -> not taken
    instr(7'b1100011, 3'b000, 1'b0);
    flags = 4'b0000;
    step; step; check("beq_pc", pc_write, 0);
    step; check("beq_s0", state, 0);
    // illegal opcode
    instr(7'b1111111, 3'b000, 1'b0);
    step; check("ill_s1", state, 1); check("ill_pulse", illegal, 1);
    step; check("ill_s0", state, 0); check("ill_clr", {illegal, mem_write, reg_write}, 0);
    // jal then lui
    instr(7'b1101111, 3'b000, 1'b0);
    step; check("jal_s1", state, 1); check("jal_imm", imm_src, 3'b011);
    step; check("jal_s10", state, 10); check("jal_pc", {pc_write, alu_src_a, alu_src_b}, 5'b10110);
    step; check("jal_s8", state, 8);
    step; check("jal_s0", state, 0);
    instr(7'b0110111, 3'b000, 1'b0);
    step; check("lui_s1", state, 1); check("lui_imm", imm_src, 3'b100);
    step; check("lui_s11", state, 11); check("lui_a", alu_src_a, 2'b11);
    step; check("lui_s8", state, 8);
    step; check("lui_s0", state, 0);
    // async reset in the middle of EXECR
    instr(7'b0110011, 3'b000, 1'b0);
    step; step; check("ar_s6", state, 6);
    reset = 1'b0;
    #1; check("ar_state", state, 0); check("ar_strobes", strobes(), 0);
    step; check("ar_hold", {state, 5'(strobes())}, 0);
    reset = 1'b1;
    #1; check("ar_fetch", state, 0); check("ar_fetch_ir", ir_write, 1);
    step; check("ar_s1", state, 1);
    step; check("ar_s6b", state, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
